// File: rtl/pll_lock_sequencer.sv
// Power-up and recovery sequencer for an iCE40 PLL: holds the PLL in reset, filters LOCK,
// gates the system reset on a stable lock and falls back to bypass after repeated failures.
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 64,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 8
) (
    input  logic             REFERENCECLK,
    input  logic             RESET,
    input  logic             LOCK,
    input  logic             RESTART,
    input  logic             FORCE_BYPASS,
    output logic             PLL_RESETB,
    output logic             PLL_BYPASS,
    output logic             SYS_RESETN,
    output logic             READY,
    output logic             BYPASS_ACTIVE,
    output logic [1:0]       RETRY_COUNT,
    output logic [CNT_W-1:0] LOCK_LOST_COUNT,
    output logic [2:0]       STATE
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    TMO_MAX  = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0]    STB_MAX  = SW'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] LOST_MAX = '1;

    typedef enum logic [2:0] {
        S_RESET_HOLD  = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_LOCK_FILTER = 3'd2,
        S_RUN         = 3'd3,
        S_BYPASS      = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       lock_pipe_reg;
    logic [RW-1:0]    rst_cnt_reg, rst_cnt_next;
    logic [TW-1:0]    tmo_cnt_reg, tmo_cnt_next, tmo_inc;
    logic [SW-1:0]    stb_cnt_reg, stb_cnt_next, stb_inc;
    logic [1:0]       retry_reg, retry_next;
    logic [2:0]       retry_inc;
    logic [CNT_W-1:0] lost_reg, lost_next;
    logic             sys_resetn_reg, sys_resetn_next;
    logic             pll_resetb_reg, pll_bypass_reg, ready_reg, bypass_active_reg;
    logic             lock_sync;
    logic             fail;

    // LOCK comes straight from the PLL analog block, so bring it in through two flops
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            lock_pipe_reg <= 2'b00;
        end else begin
            lock_pipe_reg <= {lock_pipe_reg[0], LOCK};
        end
    end

    assign lock_sync = lock_pipe_reg[1];

    always_comb begin
        state_next      = state_reg;
        rst_cnt_next    = '0;
        tmo_cnt_next    = '0;
        stb_cnt_next    = '0;
        retry_next      = retry_reg;
        lost_next       = lost_reg;
        sys_resetn_next = 1'b0;
        fail            = 1'b0;
        tmo_inc         = tmo_cnt_reg + 1'b1;
        stb_inc         = stb_cnt_reg + 1'b1;
        retry_inc       = {1'b0, retry_reg} + 3'd1;

        if (RESTART) begin
            state_next = S_RESET_HOLD;
            retry_next = '0;
        end else if (FORCE_BYPASS && (state_reg != S_BYPASS)) begin
            state_next = S_BYPASS;
        end else begin
            case (state_reg)
                S_RESET_HOLD: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        state_next = S_WAIT_LOCK;
                    end else begin
                        rst_cnt_next = rst_cnt_reg + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    tmo_cnt_next = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        fail = 1'b1;
                    end else if (lock_sync) begin
                        state_next = S_LOCK_FILTER;
                    end
                end
                S_LOCK_FILTER: begin
                    // the attempt deadline keeps running across filter dropouts
                    tmo_cnt_next = tmo_inc;
                    if (lock_sync) begin
                        stb_cnt_next = stb_inc;
                    end
                    if (lock_sync && (stb_inc == STB_MAX)) begin
                        state_next      = S_RUN;
                        retry_next      = '0;
                        sys_resetn_next = 1'b1;
                    end else if (tmo_inc == TMO_MAX) begin
                        fail = 1'b1;
                    end else if (!lock_sync) begin
                        state_next = S_WAIT_LOCK;
                    end
                end
                S_RUN: begin
                    if (!lock_sync) begin
                        state_next = S_RESET_HOLD;
                        if (lost_reg != LOST_MAX) begin
                            lost_next = lost_reg + 1'b1;
                        end
                    end else begin
                        sys_resetn_next = 1'b1;
                    end
                end
                S_BYPASS: begin
                    // settle delay on the bypass clock before releasing the system
                    if (sys_resetn_reg || (rst_cnt_reg == RST_LAST)) begin
                        sys_resetn_next = 1'b1;
                    end else begin
                        rst_cnt_next = rst_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = S_RESET_HOLD;
                end
            endcase
        end

        if (fail) begin
            retry_next = (retry_reg == 2'd3) ? 2'd3 : (retry_reg + 2'd1);
            state_next = (int'(retry_inc) >= MAX_RETRIES) ? S_BYPASS : S_RESET_HOLD;
        end
    end

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_reg         <= S_RESET_HOLD;
            rst_cnt_reg       <= '0;
            tmo_cnt_reg       <= '0;
            stb_cnt_reg       <= '0;
            retry_reg         <= '0;
            lost_reg          <= '0;
            sys_resetn_reg    <= 1'b0;
            ready_reg         <= 1'b0;
            pll_resetb_reg    <= 1'b0;
            pll_bypass_reg    <= 1'b0;
            bypass_active_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            rst_cnt_reg       <= rst_cnt_next;
            tmo_cnt_reg       <= tmo_cnt_next;
            stb_cnt_reg       <= stb_cnt_next;
            retry_reg         <= retry_next;
            lost_reg          <= lost_next;
            sys_resetn_reg    <= sys_resetn_next;
            ready_reg         <= sys_resetn_next;
            pll_resetb_reg    <= (state_next != S_RESET_HOLD);
            pll_bypass_reg    <= (state_next == S_BYPASS);
            bypass_active_reg <= (state_next == S_BYPASS);
        end
    end

    assign PLL_RESETB      = pll_resetb_reg;
    assign PLL_BYPASS      = pll_bypass_reg;
    assign SYS_RESETN      = sys_resetn_reg;
    assign READY           = ready_reg;
    assign BYPASS_ACTIVE   = bypass_active_reg;
    assign RETRY_COUNT     = retry_reg;
    assign LOCK_LOST_COUNT = lost_reg;
    assign STATE           = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a per-edge behavioural model queues expected
// outputs, and a separate monitor compares them against the DUT on the falling edge.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
    localparam int CNT_W        = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lock;
    logic             restart;
    logic             force_bp;
    logic             pll_resetb, pll_bypass, sys_resetn, ready, bypass_active;
    logic [1:0]       retry_count;
    logic [CNT_W-1:0] lost_count;
    logic [2:0]       state;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRIES (MAX_RETRIES),
        .CNT_W       (CNT_W)
    ) dut (
        .REFERENCECLK   (clk),
        .RESET          (rst_n),
        .LOCK           (lock),
        .RESTART        (restart),
        .FORCE_BYPASS   (force_bp),
        .PLL_RESETB     (pll_resetb),
        .PLL_BYPASS     (pll_bypass),
        .SYS_RESETN     (sys_resetn),
        .READY          (ready),
        .BYPASS_ACTIVE  (bypass_active),
        .RETRY_COUNT    (retry_count),
        .LOCK_LOST_COUNT(lost_count),
        .STATE          (state)
    );

    typedef struct packed {
        logic       resetb;
        logic       bypass;
        logic       sysn;
        logic       rdy;
        logic       bact;
        logic [1:0] retry;
        logic [7:0] lost;
        logic [2:0] st;
    } out_t;

    out_t exp_q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic lock_lvl = 1'b0;

    // Behavioural model: phase number (0 hold, 1 wait, 2 filter, 3 run, 4 bypass) plus
    // plain integer counts of edges spent in each activity.
    int m_phase, m_hold, m_elapsed, m_highs, m_retries, m_lost, m_byp;
    bit m_s1, m_s2;

    function automatic out_t model_out();
        out_t o;
        o.resetb = (m_phase != 0);
        o.bypass = (m_phase == 4);
        o.bact   = (m_phase == 4);
        o.sysn   = (m_phase == 3) || ((m_phase == 4) && (m_byp >= RST_CYCLES));
        o.rdy    = o.sysn;
        o.retry  = 2'(m_retries);
        o.lost   = 8'(m_lost);
        o.st     = 3'(m_phase);
        return o;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_hold = 0; m_elapsed = 0; m_highs = 0;
        m_retries = 0; m_lost = 0; m_byp = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_fail();
        m_retries = (m_retries >= 3) ? 3 : m_retries + 1;
        if (m_retries >= MAX_RETRIES) begin
            m_phase = 4; m_byp = 0;
        end else begin
            m_phase = 0; m_hold = 0;
        end
    endtask

    task automatic model_edge();
        bit seen;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lock;
        if (restart) begin
            m_phase = 0; m_hold = 0; m_retries = 0;
        end else if (force_bp && m_phase != 4) begin
            m_phase = 4; m_byp = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_hold++;
                    if (m_hold == RST_CYCLES) begin
                        m_phase = 1; m_elapsed = 0;
                    end
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == LOCK_TIMEOUT) model_fail();
                    else if (seen) begin
                        m_phase = 2; m_highs = 0;
                    end
                end
                2: begin
                    m_elapsed++;
                    if (seen) m_highs++;
                    if (seen && m_highs == LOCK_STABLE) begin
                        m_phase = 3; m_retries = 0;
                    end else if (m_elapsed == LOCK_TIMEOUT) model_fail();
                    else if (!seen) m_phase = 1;
                end
                3: begin
                    if (!seen) begin
                        m_phase = 0; m_hold = 0;
                        m_lost = (m_lost >= 255) ? 255 : m_lost + 1;
                    end
                end
                default: begin
                    if (m_byp < RST_CYCLES) m_byp++;
                end
            endcase
        end
    endtask

    // one clock cycle of stimulus; the expected result for the coming edge is queued after it
    task automatic cyc(input bit r, input bit f);
        out_t pend;
        lock     = lock_lvl;
        restart  = r;
        force_bp = f;
        model_edge();
        pend = model_out();
        @(posedge clk);
        exp_q.push_back(pend);
        #1;
    endtask

    task automatic run_to(input int target, input int maxc);
        int n = 0;
        while (m_phase != target && n < maxc) begin
            cyc(1'b0, 1'b0);
            n++;
        end
        if (m_phase != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to: phase %0d after %0d cycles, required %0d", m_phase, n, target);
        end
    endtask

    // monitor: every queued expectation is compared against what the DUT currently shows
    initial begin
        out_t got, exp;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = '{pll_resetb, pll_bypass, sys_resetn, ready, bypass_active,
                        retry_count, lost_count, state};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got st=%0d rb=%b byp=%b sysn=%b rdy=%b bact=%b retry=%0d lost=%0d, required st=%0d rb=%b byp=%b sysn=%b rdy=%b bact=%b retry=%0d lost=%0d",
                             $time, got.st, got.resetb, got.bypass, got.sysn, got.rdy, got.bact, got.retry, got.lost,
                             exp.st, exp.resetb, exp.bypass, exp.sysn, exp.rdy, exp.bact, exp.retry, exp.lost);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lock = 1'b0; restart = 1'b0; force_bp = 1'b0;
        model_reset();
        repeat (3) cyc(1'b0, 1'b0);
        rst_n = 1'b1;

        // power-up: LOCK rises 10 cycles after PLL release
        lock_lvl = 1'b0;
        run_to(1, 20);
        repeat (9) cyc(1'b0, 1'b0);
        lock_lvl = 1'b1;
        repeat (14) cyc(1'b0, 1'b0);

        // single-cycle lock loss in RUN, then relock
        lock_lvl = 1'b0;
        cyc(1'b0, 1'b0);
        lock_lvl = 1'b1;
        repeat (30) cyc(1'b0, 1'b0);

        // LOCK toggling every 5 cycles: two timeouts then bypass; LOCK ignored in bypass
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 110; i++) begin
            if (i % 5 == 0) lock_lvl = ~lock_lvl;
            cyc(1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            lock_lvl = 1'($urandom_range(0, 1));
            cyc(1'b0, 1'b0);
        end

        // FORCE_BYPASS pulse in WAIT_LOCK, then RESTART; then FORCE held across a RESTART
        lock_lvl = 1'b0;
        cyc(1'b1, 1'b0);
        run_to(1, 20);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);

        // repeated lock-loss events drive LOCK_LOST_COUNT into saturation
        for (int ev = 0; ev < 300; ev++) begin
            lock_lvl = 1'b1;
            run_to(3, 60);
            repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0);
            lock_lvl = 1'b0;
            repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0);
        end
        lock_lvl = 1'b1;
        run_to(3, 60);
        repeat (3) cyc(1'b0, 1'b0);

        // random traffic: wandering LOCK, rare RESTART / FORCE_BYPASS pulses
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 7) lock_lvl = ~lock_lvl;
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 299) == 0));
        end

        // asynchronous reset while in RUN, then a full sequence from scratch
        cyc(1'b1, 1'b0);
        lock_lvl = 1'b1;
        run_to(3, 80);
        cyc(1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_out());
        -> chk_ev;
        repeat (2) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        run_to(3, 80);
        repeat (4) cyc(1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
